// File: rtl/wb_pkg.sv
// Shared codes and types for the writeback stage and its late-write FIFO.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_AW = 5;

  typedef enum logic [1:0] {
    WDSEL_ALU  = 2'd0,
    WDSEL_DM   = 2'd1,
    WDSEL_PC8  = 2'd2,
    WDSEL_RSVD = 2'd3
  } wdsel_e;

  typedef enum logic [2:0] {
    LDEXT_LW  = 3'd0,
    LDEXT_LB  = 3'd1,
    LDEXT_LBU = 3'd2,
    LDEXT_LH  = 3'd3,
    LDEXT_LHU = 3'd4
  } ldext_e;

  typedef struct packed {
    logic [WB_REG_AW-1:0] a3;
    logic [WB_DATA_W-1:0] data;
  } wb_late_t;

endpackage

// File: rtl/wb_late_fifo.sv
// Late-write FIFO: wrap-bit pointers, pending-register mask and head starvation tracking.
module wb_late_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STARVE = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic [REG_AW-1:0]        push_a3,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     push_ready,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [REG_AW-1:0]        head_a3,
  output logic [DATA_W-1:0]        head_data,
  output logic [(2**REG_AW)-1:0]   pend_mask,
  output logic                     stall_req
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE + 1);

  logic [PW:0]       wr_ptr, rd_ptr, count;
  logic [REG_AW-1:0] a3_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     offs;
  logic [CW-1:0]     starve_cnt;
  logic              empty, full, push_en, pop_en;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign count      = wr_ptr - rd_ptr;
  assign push_ready = !full;
  // Writes to $0 are acknowledged but never occupy a slot.
  assign push_en    = push_valid && !full && (push_a3 != '0);
  assign pop_en     = pop && !empty;

  assign head_valid = !empty;
  assign head_a3    = a3_mem[rd_ptr[PW-1:0]];
  assign head_data  = data_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push_en) begin
      a3_mem[wr_ptr[PW-1:0]]   <= push_a3;
      data_mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      if (empty || pop_en)
        starve_cnt <= '0;
      else if (starve_cnt < CW'(STARVE))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // An entry is live when its distance from the read index is below the occupancy.
  always_comb begin
    pend_mask = '0;
    offs      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr[PW-1:0];
      if ({1'b0, offs} < count) pend_mask[a3_mem[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign stall_req = (starve_cnt >= CW'(STARVE)) || full;

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback stage: W register, load extender, WD mux and single GRF port arbiter.
module wb_retire_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STARVE = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Reg_Rst,
  input  logic                   We,
  input  logic [31:0]            PC_in,
  input  logic [DATA_W-1:0]      Y_in,
  input  logic [DATA_W-1:0]      DR_in,
  input  logic [1:0]             Addr_in,
  input  logic [REG_AW-1:0]      A3_in,
  input  logic                   RFWr_in,
  input  logic [1:0]             WDSel_in,
  input  logic [2:0]             LdExt_in,
  input  logic                   Lw_valid,
  output logic                   Lw_ready,
  input  logic [REG_AW-1:0]      Lw_a3,
  input  logic [DATA_W-1:0]      Lw_data,
  output logic [REG_AW-1:0]      A3_out,
  output logic [DATA_W-1:0]      WD_out,
  output logic                   RFWr_out,
  output logic [31:0]            PC_out,
  output logic                   Fwd_Valid,
  output logic [REG_AW-1:0]      Fwd_A3,
  output logic [DATA_W-1:0]      Fwd_WD,
  output logic [(2**REG_AW)-1:0] Pend_Mask,
  output logic                   Stall_Req
);

  logic              valid_q, rfwr_q;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] y_q, dr_q;
  logic [1:0]        addr_q;
  logic [REG_AW-1:0] a3_q;
  wdsel_e            wdsel_q;
  logic [2:0]        ldext_q;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] dm_wd, wd;
  logic [31:0]       pc8;
  logic              pw, pop;
  logic              head_valid;
  logic [REG_AW-1:0] head_a3;
  logic [DATA_W-1:0] head_data;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= 1'b0;
      rfwr_q  <= 1'b0;
      pc_q    <= '0;
      y_q     <= '0;
      dr_q    <= '0;
      addr_q  <= '0;
      a3_q    <= '0;
      wdsel_q <= WDSEL_ALU;
      ldext_q <= '0;
    end else if (Reg_Rst) begin
      valid_q <= 1'b0;
      rfwr_q  <= 1'b0;
      pc_q    <= '0;
      y_q     <= '0;
      dr_q    <= '0;
      addr_q  <= '0;
      a3_q    <= '0;
      wdsel_q <= WDSEL_ALU;
      ldext_q <= '0;
    end else if (We) begin
      valid_q <= 1'b1;
      rfwr_q  <= RFWr_in;
      pc_q    <= PC_in;
      y_q     <= Y_in;
      dr_q    <= DR_in;
      addr_q  <= Addr_in;
      a3_q    <= A3_in;
      wdsel_q <= wdsel_e'(WDSel_in);
      ldext_q <= LdExt_in;
    end
  end

  assign byte_sel = dr_q[{addr_q, 3'b000} +: 8];
  assign half_sel = addr_q[1] ? dr_q[31:16] : dr_q[15:0];
  assign pc8      = pc_q + 32'd8;

  always_comb begin
    dm_wd = dr_q;
    case (ldext_q)
      LDEXT_LB:  dm_wd = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LDEXT_LBU: dm_wd = {{(DATA_W-8){1'b0}}, byte_sel};
      LDEXT_LH:  dm_wd = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LDEXT_LHU: dm_wd = {{(DATA_W-16){1'b0}}, half_sel};
      default:   dm_wd = dr_q;
    endcase
  end

  always_comb begin
    wd = y_q;
    case (wdsel_q)
      WDSEL_DM:  wd = dm_wd;
      WDSEL_PC8: wd = DATA_W'(pc8);
      default:   wd = y_q;
    endcase
  end

  assign pw        = valid_q && rfwr_q && (a3_q != '0);
  assign pop       = !pw && head_valid;
  assign Fwd_Valid = pw;
  assign Fwd_A3    = a3_q;
  assign Fwd_WD    = wd;
  assign PC_out    = pc_q;

  always_comb begin
    RFWr_out = 1'b0;
    A3_out   = '0;
    WD_out   = '0;
    if (pw) begin
      RFWr_out = 1'b1;
      A3_out   = a3_q;
      WD_out   = wd;
    end else if (head_valid) begin
      RFWr_out = 1'b1;
      A3_out   = head_a3;
      WD_out   = head_data;
    end
  end

  wb_late_fifo #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW),
    .DATA_W (DATA_W),
    .STARVE (STARVE)
  ) u_late_fifo (
    .clk        (Clk),
    .rst_n      (Rst),
    .push_valid (Lw_valid),
    .push_a3    (Lw_a3),
    .push_data  (Lw_data),
    .push_ready (Lw_ready),
    .pop        (pop),
    .head_valid (head_valid),
    .head_a3    (head_a3),
    .head_data  (head_data),
    .pend_mask  (Pend_Mask),
    .stall_req  (Stall_Req)
  );

endmodule
